// File: rtl/dmux_seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// dmux_seq_ctrl_pkg
// Shared types and defaults for the demux sequencer:
//   - state_t    : sequencer states (IDLE, SETUP, HOLD, GAP)
//   - DEF_*      : default select width and timing windows
//   - cnt_width(): width of the shared SETUP/HOLD down-counter
// -----------------------------------------------------------------------------
package dmux_seq_ctrl_pkg;

    localparam int DEF_SEL_W     = 3;
    localparam int DEF_SETUP_CYC = 1;
    localparam int DEF_HOLD_CYC  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        HOLD  = 2'd2,
        GAP   = 2'd3
    } state_t;

    // Counter must hold the larger of the two window reloads.
    function automatic int cnt_width(input int setup_cyc, input int hold_cyc);
        int max_cyc;
        max_cyc = (setup_cyc > hold_cyc) ? setup_cyc : hold_cyc;
        return $clog2(max_cyc + 1);
    endfunction

endpackage

// File: rtl/dmux_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// dmux_seq_ctrl_if
// Bundle between a requester, the sequencer and the downstream 1-to-N demux.
//   in_valid/in_ready/in_dest/in_data : routing request handshake
//   scan_en                           : auto-scan request (optional feature)
//   dmux_sel/dmux_din                 : demux select and data-in pins
//   busy/done                         : transfer status
// Modports: master = requester side, slave = sequencer side.
// -----------------------------------------------------------------------------
interface dmux_seq_ctrl_if
    import dmux_seq_ctrl_pkg::*;
#(
    parameter int SEL_W = DEF_SEL_W
) ();

    logic             in_valid;
    logic             in_ready;
    logic [SEL_W-1:0] in_dest;
    logic             in_data;
    logic             scan_en;
    logic [SEL_W-1:0] dmux_sel;
    logic             dmux_din;
    logic             busy;
    logic             done;

    modport master (
        output in_valid, in_dest, in_data, scan_en,
        input  in_ready, dmux_sel, dmux_din, busy, done
    );

    modport slave (
        input  in_valid, in_dest, in_data, scan_en,
        output in_ready, dmux_sel, dmux_din, busy, done
    );

endinterface

// File: rtl/dmux_seq_tmr.sv
// -----------------------------------------------------------------------------
// dmux_seq_tmr
// Loadable down-counter with zero flag, shared by the SETUP and HOLD windows.
//   clk, rst_n  : clock, asynchronous active-low reset (count -> 0)
//   load_i      : load load_val_i (has priority over dec_i)
//   load_val_i  : reload value
//   dec_i       : decrement by one; saturates at zero
//   zero_o      : count is zero
// -----------------------------------------------------------------------------
module dmux_seq_tmr #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/dmux_seq_ctrl.sv
// -----------------------------------------------------------------------------
// dmux_seq_ctrl
// Glitch-free sequencer in front of a 1-to-2**SEL_W demultiplexer. Each
// accepted request {dest, data} runs:
//   SETUP : select set to dest, din held 0 for SETUP_CYC cycles
//   HOLD  : din carries data for HOLD_CYC cycles
//   GAP   : din back to 0 (done pulses), select still held, for one cycle
// so the select only ever changes while din is 0.
// Ports:
//   clk    : clock, all state on rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : dmux_seq_ctrl_if.slave (request handshake, demux pins, status)
// Parameters: SEL_W, SETUP_CYC (>=1), HOLD_CYC (>=1).
// Optional feature macro: DMUX_SEQ_CTRL_SCAN_EN -- when defined, an idle
// controller with scan_en=1 and no request self-issues data=1 transfers to
// an incrementing, wrapping scan pointer. Explicit requests win over scan.
// -----------------------------------------------------------------------------
module dmux_seq_ctrl
    import dmux_seq_ctrl_pkg::*;
#(
    parameter int SEL_W     = DEF_SEL_W,
    parameter int SETUP_CYC = DEF_SETUP_CYC,
    parameter int HOLD_CYC  = DEF_HOLD_CYC
) (
    input  logic           clk,
    input  logic           rst_n,
    dmux_seq_ctrl_if.slave bus
);

    localparam int               CNT_W      = cnt_width(SETUP_CYC, HOLD_CYC);
    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYC - 1);

    state_t           state_q;
    logic [SEL_W-1:0] sel_q;
    logic             data_q;
    logic             din_q;
    logic             busy_q;
    logic             done_q;
    logic             ready_q;

    logic             idle_rdy;
    logic             accept;
    logic [SEL_W-1:0] acc_dest;
    logic             acc_data;

    logic             tmr_load;
    logic [CNT_W-1:0] tmr_load_val;
    logic             tmr_dec;
    logic             tmr_zero;

    // ready_q is 0 in IDLE only on the first cycle after reset release,
    // which keeps a request pending across reset from being taken early.
    assign idle_rdy = (state_q == IDLE) && ready_q;

`ifdef DMUX_SEQ_CTRL_SCAN_EN
    logic [SEL_W-1:0] scan_ptr_q;

    always_comb begin
        accept   = idle_rdy && (bus.in_valid || bus.scan_en);
        acc_dest = bus.in_valid ? bus.in_dest : scan_ptr_q;
        acc_data = bus.in_valid ? bus.in_data : 1'b1;
    end

    // Pointer advances only when scan actually wins the accept; the natural
    // SEL_W-bit overflow provides the wrap back to output 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_ptr_q <= '0;
        end else if (idle_rdy && !bus.in_valid && bus.scan_en) begin
            scan_ptr_q <= scan_ptr_q + 1'b1;
        end
    end
`else
    logic unused_scan_en;
    assign unused_scan_en = bus.scan_en;

    always_comb begin
        accept   = idle_rdy && bus.in_valid;
        acc_dest = bus.in_dest;
        acc_data = bus.in_data;
    end
`endif

    // One timer serves both windows: loaded with the SETUP reload on accept
    // and with the HOLD reload on the SETUP->HOLD transition.
    always_comb begin
        tmr_load     = accept || ((state_q == SETUP) && tmr_zero);
        tmr_load_val = (state_q == SETUP) ? HOLD_LOAD : SETUP_LOAD;
        tmr_dec      = ((state_q == SETUP) || (state_q == HOLD)) && !tmr_zero;
    end

    dmux_seq_tmr #(
        .CNT_W (CNT_W)
    ) u_tmr (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_load_val),
        .dec_i      (tmr_dec),
        .zero_o     (tmr_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sel_q   <= '0;
            data_q  <= 1'b0;
            din_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        sel_q   <= acc_dest;
                        data_q  <= acc_data;
                        din_q   <= 1'b0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= SETUP;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                SETUP: begin
                    if (tmr_zero) begin
                        din_q   <= data_q;
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (tmr_zero) begin
                        din_q   <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= GAP;
                    end
                end
                GAP: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready = ready_q;
    assign bus.dmux_sel = sel_q;
    assign bus.dmux_din = din_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_dmux_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmux_seq_ctrl
// Directed bench for dmux_seq_ctrl with default parameters (SEL_W=3,
// SETUP_CYC=1, HOLD_CYC=4, period 7). Scan checks are built only when
// DMUX_SEQ_CTRL_SCAN_EN is defined.
// -----------------------------------------------------------------------------
module tb_dmux_seq_ctrl;

    // Hand-derived timing for the default build.
    localparam int T_SETUP = 1;
    localparam int T_HOLD  = 4;
    localparam int T_SEQ   = 7;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dmux_seq_ctrl_if #(.SEL_W(3)) bus ();

    dmux_seq_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_idle(input string tag, input logic [2:0] sel, input logic rdy);
        check({tag, "_sel"},   32'(bus.dmux_sel), 32'(sel));
        check({tag, "_din"},   32'(bus.dmux_din), 32'(1'b0));
        check({tag, "_busy"},  32'(bus.busy),     32'(1'b0));
        check({tag, "_done"},  32'(bus.done),     32'(1'b0));
        check({tag, "_ready"}, 32'(bus.in_ready), 32'(rdy));
    endtask

    // Runs one 7-cycle transfer starting at the next rising edge.
    // drive : present {dest,data} as a request (else expect a scan self-issue)
    // keep  : keep in_valid high afterwards (back-to-back)
    // inject: raise a dest=6 request mid-transfer
    task automatic xfer(input logic [2:0] dest, input logic data,
                        input bit drive, input bit keep, input bit inject);
        logic exp_din;
        if (drive) begin
            bus.in_valid = 1'b1;
            bus.in_dest  = dest;
            bus.in_data  = data;
        end
        @(posedge clk);
        for (int k = 0; k < T_SEQ; k++) begin
            @(negedge clk);
            exp_din = ((k >= T_SETUP) && (k < T_SETUP + T_HOLD)) ? data : 1'b0;
            check("x_sel",   32'(bus.dmux_sel), 32'(dest));
            check("x_din",   32'(bus.dmux_din), 32'(exp_din));
            check("x_done",  32'(bus.done),     32'(k == T_SETUP + T_HOLD));
            check("x_busy",  32'(bus.busy),     32'(k <= T_SETUP + T_HOLD));
            check("x_ready", 32'(bus.in_ready), 32'(k == T_SETUP + T_HOLD + 1));
            if (k == 0 && drive && !keep) begin
                // Changes after acceptance must be ignored.
                bus.in_valid = 1'b0;
                bus.in_dest  = ~dest;
                bus.in_data  = ~data;
            end
            if (k == 2 && inject) begin
                bus.in_valid = 1'b1;
                bus.in_dest  = 3'd6;
                bus.in_data  = 1'b1;
            end
        end
        $display("xfer dest=%0d data=%0d src=%s", dest, data, drive ? "req" : "scan");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_dest  = 3'd0;
        bus.in_data  = 1'b0;
        bus.scan_en  = 1'b0;
        rst_n        = 1'b0;

        // Reset and release: in_ready rises one edge after release.
        repeat (3) @(negedge clk);
        check_idle("rst", 3'd0, 1'b0);
        rst_n = 1'b1;
        #1;
        check("rel_ready0", 32'(bus.in_ready), 32'(1'b0));
        @(negedge clk);
        check_idle("rel", 3'd0, 1'b1);
        $display("reset release checked");

`ifndef DMUX_SEQ_CTRL_SCAN_EN
        // Without the scan feature scan_en must do nothing.
        bus.scan_en = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_idle("noscan", 3'd0, 1'b1);
        end
        bus.scan_en = 1'b0;
        $display("scan_en ignored checked");
`endif

        // Single request.
        xfer(3'd5, 1'b1, 1'b1, 1'b0, 1'b0);

        // Back-to-back dest 0..7 with in_valid held high.
        for (int d = 0; d < 8; d++) begin
            xfer(3'(d), 1'b1, 1'b1, (d != 7), 1'b0);
        end

        // data=0 still runs the full sequence.
        xfer(3'd3, 1'b0, 1'b1, 1'b0, 1'b0);

        // Reset asserted during HOLD.
        bus.in_valid = 1'b1;
        bus.in_dest  = 3'd6;
        bus.in_data  = 1'b1;
        @(posedge clk);
        repeat (3) @(negedge clk);
        check("mid_din_hi", 32'(bus.dmux_din), 32'(1'b1));
        #2;
        rst_n = 1'b0;
        #1;
        check_idle("arst", 3'd0, 1'b0);
        bus.in_valid = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check_idle("inrst", 3'd0, 1'b0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        repeat (3) begin
            @(negedge clk);
            check_idle("postrst", 3'd0, 1'b1);
        end
        $display("reset during hold checked");
        xfer(3'd2, 1'b1, 1'b1, 1'b0, 1'b0);

`ifdef DMUX_SEQ_CTRL_SCAN_EN
        // Fresh reset so the scan pointer starts at 0.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.scan_en = 1'b1;
        @(negedge clk);
        for (int p = 0; p < 8; p++) begin
            xfer(3'(p), 1'b1, 1'b0, 1'b0, 1'b0);
        end
        xfer(3'd0, 1'b1, 1'b0, 1'b0, 1'b1);  // wrap, request injected mid-scan
        xfer(3'd6, 1'b1, 1'b1, 1'b0, 1'b0);  // request served ahead of scan
        xfer(3'd1, 1'b1, 1'b0, 1'b0, 1'b0);  // scan resumes where it left off
        bus.scan_en = 1'b0;
`endif

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
